// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_pkg;
  localparam logic        MODE_SQUARE = 1'b0;
  localparam logic        MODE_PULSE  = 1'b1;
  localparam int unsigned MIN_DIV     = 2;
endpackage

// File: rtl/div_cfg_slot.sv
// Single-entry divisor slot: valid/ready intake, clamping, and deferred apply.
module div_cfg_slot
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             period_end,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_data,
  output logic             div_ready,
  output logic             div_pending,
  output logic [WIDTH-1:0] div_active
);
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] data_clamped;
  logic             xfer;
  logic             apply;

  assign div_ready    = ~div_pending;
  assign xfer         = div_valid & div_ready;
  // While stalled or restarting there is no period in flight to protect.
  assign apply        = div_pending & (clr | ~en | period_end);
  assign data_clamped = (div_data < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_data;

  // xfer needs an empty slot and apply needs a full one, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_active  <= WIDTH'(DEFAULT_DIV);
      pend_q      <= '0;
      div_pending <= 1'b0;
    end else if (xfer) begin
      pend_q      <= data_clamped;
      div_pending <= 1'b1;
    end else if (apply) begin
      div_active  <= pend_q;
      div_pending <= 1'b0;
    end
  end
endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: square wave or one-cycle tick train from clk.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_data,
  output logic             div_ready,
  output logic             div_pending,
  output logic [WIDTH-1:0] div_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tick,
  output logic             clk_out
);
  if (DEFAULT_DIV < MIN_DIV || 64'(DEFAULT_DIV) >= (64'd1 << WIDTH)) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV out of range for WIDTH");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_n;
  logic             tick_n;
  logic             wrap;
  logic [WIDTH:0]   half;
  logic             sq_n;

  div_cfg_slot #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_slot (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr         (clr),
    .period_end  (wrap),
    .div_valid   (div_valid),
    .div_data    (div_data),
    .div_ready   (div_ready),
    .div_pending (div_pending),
    .div_active  (div_o)
  );

  // >= rather than ==: a divisor shrunk during a pause may leave cnt past D-1,
  // and this closes the period on the next enabled edge instead of running off.
  assign wrap = en & ~clr & (cnt >= div_o - 1'b1);

  always_comb begin
    cnt_n  = cnt;
    tick_n = 1'b0;
    if (clr) begin
      cnt_n = '0;
    end else if (en) begin
      cnt_n  = wrap ? '0 : cnt + 1'b1;
      tick_n = wrap;
    end
  end

  // Extra bit so D = 2**WIDTH-1 does not overflow the ceil(D/2) threshold.
  assign half = ({1'b0, div_o} + 1'b1) >> 1;
  assign sq_n = {1'b0, cnt_n} < half;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      tick <= tick_n;
      if (clr)
        clk_out <= 1'b0;
      else if (en)
        clk_out <= (mode == MODE_PULSE) ? tick_n : sq_n;
    end
  end

  assign cnt_o = cnt;
endmodule

// File: tb/tb_clk_div_prog.sv
// Table, directed and random checks of clk_div_prog against a period-level model.
module tb_clk_div_prog;
  localparam int W   = 8;
  localparam int DEF = 6;

  logic         clk = 1'b0;
  logic         rst, en, clr, mode, div_valid;
  logic [W-1:0] div_data;
  logic         div_ready, div_pending, tick, clk_out;
  logic [W-1:0] div_o, cnt_o;

  always #5 clk = ~clk;

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
    .div_valid(div_valid), .div_data(div_data), .div_ready(div_ready),
    .div_pending(div_pending), .div_o(div_o), .cnt_o(cnt_o),
    .tick(tick), .clk_out(clk_out)
  );

  int checks = 0, failures = 0;

  // Model: phase within the period, active divisor, a one-deep queue of offers.
  int m_cnt, m_d;
  int m_pend[$];
  bit m_tick, m_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit c, input bit md,
                            input bit v, input int d);
    bit xfer, wrap;
    int d_old;
    if (r) begin
      m_cnt = 0; m_d = DEF; m_pend.delete(); m_tick = 0; m_clk = 0;
      return;
    end
    xfer  = v && (m_pend.size() == 0);
    wrap  = e && !c && (m_cnt + 1 >= m_d);
    d_old = m_d;
    if (m_pend.size() != 0 && (c || !e || wrap)) m_d = m_pend.pop_front();
    if (xfer) m_pend.push_back(d < 2 ? 2 : d);
    if (c) begin
      m_cnt = 0; m_tick = 0; m_clk = 0;
    end else if (e) begin
      m_cnt  = wrap ? 0 : m_cnt + 1;
      m_tick = wrap;
      // high while the phase lies in the first ceil(D/2) slots
      m_clk  = md ? wrap : (2 * m_cnt < d_old);
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit c, input bit md,
                       input bit v, input int d);
    @(negedge clk);
    rst = r; en = e; clr = c; mode = md; div_valid = v; div_data = W'(d);
    model_step(r, e, c, md, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":cnt"},   cnt_o,       m_cnt);
    chk({tag, ":div"},   div_o,       m_d);
    chk({tag, ":pend"},  div_pending, m_pend.size() != 0);
    chk({tag, ":ready"}, div_ready,   m_pend.size() == 0);
    chk({tag, ":tick"},  tick,        m_tick);
    chk({tag, ":clk"},   clk_out,     m_clk);
  endtask

  task automatic run(input string tag, input int n, input bit md);
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, 0, md, 0, 0);
      check_model(tag);
    end
  endtask

  typedef struct {
    bit r, e;
    int exp_cnt;
    bit exp_tick, exp_clk;
  } vec_t;

  vec_t vt[15];

  initial begin
    rst = 1; en = 0; clr = 0; mode = 0; div_valid = 0; div_data = '0;

    vt[0]  = '{1, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 1, 0, 1};  vt[2]  = '{0, 1, 2, 0, 1};
    vt[3]  = '{0, 1, 3, 0, 0};  vt[4]  = '{0, 1, 4, 0, 0};
    vt[5]  = '{0, 1, 5, 0, 0};  vt[6]  = '{0, 1, 0, 1, 1};
    vt[7]  = '{0, 1, 1, 0, 1};  vt[8]  = '{0, 1, 2, 0, 1};
    vt[9]  = '{0, 1, 3, 0, 0};  vt[10] = '{0, 1, 4, 0, 0};
    vt[11] = '{0, 1, 5, 0, 0};  vt[12] = '{0, 1, 0, 1, 1};
    vt[13] = '{0, 0, 0, 0, 1};  vt[14] = '{0, 1, 1, 0, 1};
    for (int i = 0; i < 15; i++) begin
      cycle(vt[i].r, vt[i].e, 0, 0, 0, 0);
      chk($sformatf("tbl%0d:cnt", i),  cnt_o,   vt[i].exp_cnt);
      chk($sformatf("tbl%0d:tick", i), tick,    vt[i].exp_tick);
      chk($sformatf("tbl%0d:clk", i),  clk_out, vt[i].exp_clk);
      chk($sformatf("tbl%0d:div", i),  div_o,   DEF);
      chk($sformatf("tbl%0d:pend", i), div_pending, 0);
    end

    // New divisor 5 offered mid-period; it waits out the current 6-cycle period.
    cycle(1, 0, 0, 0, 0, 0); check_model("rstA");
    run("preA", 2, 0);
    cycle(0, 1, 0, 0, 1, 5); check_model("offerA");
    chk("A:div_held", div_o, 6);
    chk("A:pending",  div_pending, 1);
    run("A", 20, 0);
    chk("A:div_applied", div_o, 5);

    // Zero clamps to the minimum divisor.
    cycle(0, 1, 0, 0, 1, 0); check_model("offerB");
    run("B", 12, 0);
    chk("B:div_clamped", div_o, 2);

    // Back-to-back offers with valid held: the second stalls until the slot frees.
    cycle(0, 1, 0, 0, 1, 4); check_model("offerC4");
    chk("C:ready_low", div_ready, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, 0, 1, 9); check_model("C_hold");
      if (m_d == 4 && m_pend.size() != 0) break;
    end
    chk("C:div4_active", div_o, 4);
    chk("C:nine_pending", div_pending, 1);
    run("C", 6, 0);
    chk("C:div9_active", div_o, 9);

    // Pause at cnt=3 with D=6, then resume.
    cycle(1, 0, 0, 0, 0, 0); check_model("rstD");
    run("preD", 3, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0, 0); check_model("D_pause");
      chk("D:cnt_held", cnt_o, 3);
    end
    run("D_resume", 2, 0);
    chk("D:no_tick_early", tick, 0);
    run("D_resume", 1, 0);
    chk("D:tick_after_3", tick, 1);

    // Pulse mode with D=4.
    cycle(0, 1, 0, 1, 1, 4); check_model("offerE");
    run("E", 16, 1);
    chk("E:div4", div_o, 4);

    // Phase restart at cnt=2.
    cycle(1, 0, 0, 0, 0, 0); check_model("rstF");
    run("preF", 2, 0);
    cycle(0, 1, 1, 0, 0, 0); check_model("F_clr");
    chk("F:cnt0", cnt_o, 0);
    chk("F:clk0", clk_out, 0);
    run("F", 5, 0);
    chk("F:no_tick_yet", tick, 0);
    run("F", 1, 0);
    chk("F:tick_at_D", tick, 1);

    // Reset with a divisor pending.
    run("preG", 2, 0);
    cycle(0, 1, 0, 0, 1, 9); check_model("offerG");
    cycle(1, 1, 0, 0, 0, 0); check_model("rstG");
    chk("G:div_default", div_o, DEF);
    chk("G:pend_clear", div_pending, 0);

    // Randomized traffic against the model.
    begin
      bit md = 0;
      for (int i = 0; i < 3000; i++) begin
        bit r, e, c, v;
        int d;
        r = ($urandom_range(0, 499) == 0);
        e = ($urandom_range(0, 9) != 0);
        c = ($urandom_range(0, 49) == 0);
        v = ($urandom_range(0, 3) == 0);
        d = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
        if ($urandom_range(0, 99) == 0) md = ~md;
        cycle(r, e, c, md, v, d);
        check_model("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
